// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the bubble instruction, and the stall/flush strobe bundle.
package hazard_pkg;

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MDU_WAIT = 1'b1;

  typedef enum logic {
    RUN      = ST_RUN,
    MDU_WAIT = ST_MDU_WAIT
  } state_e;

  // Pipeline registers load this on flush: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } hz_ctl_t;

  localparam hz_ctl_t HZ_NONE = '0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load
// currently in EX has not yet produced. x0 never creates a dependency.
module load_use_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       hazard_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign hazard_o = ex_memread_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for the 5-stage core: memory wait states, MDU
// occupancy, branch squash and load-use bubbles, plus a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_mdu_op_i,
  input  logic             mdu_done_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             mdu_start_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  state_e           state_q, state_d;
  logic             done_pend_q, done_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  hz_ctl_t          ctl;
  logic             mdu_start;
  logic             memstall, done_seen, mdu_busy, load_use;

  load_use_detect u_lu (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_memread_i (ex_memread_i),
    .hazard_o     (load_use)
  );

  assign memstall  = mem_req_i & ~mem_ready_i;
  // A completion latched during a memory stall counts as done later on.
  assign done_seen = mdu_done_i | done_pend_q;
  assign mdu_busy  = (state_q == RUN) ? ex_mdu_op_i : ~done_seen;

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    ctl         = HZ_NONE;
    mdu_start   = (state_q == RUN) & ex_mdu_op_i & ~memstall & ~rst;

    if (memstall) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_stall  = 1'b1;
      ctl.exmem_stall = 1'b1;
      ctl.memwb_flush = 1'b1;
    end else if (mdu_busy) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_stall  = 1'b1;
      ctl.exmem_flush = 1'b1;
    end else if (ex_branch_taken_i) begin
      // The dependent instruction is squashed, so load-use never matters here.
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
    end else if (load_use) begin
      ctl.pc_stall   = 1'b1;
      ctl.ifid_stall = 1'b1;
      ctl.idex_flush = 1'b1;
    end

    if (state_q == RUN) begin
      if (mdu_start) state_d = MDU_WAIT;
    end else begin
      if (memstall & mdu_done_i) done_pend_d = 1'b1;
      if (done_seen & ~memstall) begin
        state_d     = RUN;
        done_pend_d = 1'b0;
      end
    end

    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, ctl.pc_stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      done_pend_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      done_pend_q    <= done_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mdu_start_o    = mdu_start;
  assign pc_stall_o     = ctl.pc_stall;
  assign ifid_stall_o   = ctl.ifid_stall;
  assign idex_stall_o   = ctl.idex_stall;
  assign exmem_stall_o  = ctl.exmem_stall;
  assign ifid_flush_o   = ctl.ifid_flush;
  assign idex_flush_o   = ctl.idex_flush;
  assign exmem_flush_o  = ctl.exmem_flush;
  assign memwb_flush_o  = ctl.memwb_flush;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences and
// random traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_use_rs1_i, id_use_rs2_i, ex_memread_i, ex_branch_taken_i;
  logic        ex_mdu_op_i, mdu_done_i, mem_req_i, mem_ready_i;
  logic        mdu_start_o, pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o;
  logic        ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
  logic [31:0] stall_cycles_o;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
    .ex_branch_taken_i(ex_branch_taken_i), .ex_mdu_op_i(ex_mdu_op_i),
    .mdu_done_i(mdu_done_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .mdu_start_o(mdu_start_o), .pc_stall_o(pc_stall_o),
    .ifid_stall_o(ifid_stall_o), .idex_stall_o(idex_stall_o),
    .exmem_stall_o(exmem_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .memwb_flush_o(memwb_flush_o), .stall_cycles_o(stall_cycles_o)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       memread, br, mdu, done, req, rdy;
  } in_t;

  typedef struct {
    in_t        v;
    logic [8:0] exp;  // {start, pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f}
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: "waiting for MDU", "completion seen during memory stall", counter.
  logic        m_wait = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_cnt  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs();
    return {mdu_start_o, pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
            ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o};
  endfunction

  function automatic logic [8:0] model_out(input in_t v);
    logic memstall, lu, busy, start;
    memstall = v.req && !v.rdy;
    lu = v.memread && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    busy  = m_wait ? !(v.done || m_pend) : v.mdu;
    start = !m_wait && v.mdu && !memstall && !v.rst;
    if (memstall)  return {start, 8'b1111_0001};
    if (busy)      return {start, 8'b1110_0010};
    if (v.br)      return {start, 8'b0000_1100};
    if (lu)        return {start, 8'b1100_0100};
    return {start, 8'b0000_0000};
  endfunction

  function automatic void model_step(input in_t v, input logic [8:0] o);
    logic memstall;
    memstall = v.req && !v.rdy;
    if (v.rst) begin
      m_wait = 1'b0; m_pend = 1'b0; m_cnt = '0;
      return;
    end
    m_cnt = m_cnt + 32'(o[7]);
    if (!m_wait) begin
      if (o[8]) m_wait = 1'b1;
    end else begin
      if (memstall && v.done) m_pend = 1'b1;
      if ((v.done || m_pend) && !memstall) begin
        m_wait = 1'b0; m_pend = 1'b0;
      end
    end
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
    id_use_rs1_i = v.u1; id_use_rs2_i = v.u2; ex_rd_i = v.rd;
    ex_memread_i = v.memread; ex_branch_taken_i = v.br; ex_mdu_op_i = v.mdu;
    mdu_done_i = v.done; mem_req_i = v.req; mem_ready_i = v.rdy;
  endtask

  // One cycle: inputs driven 1 time unit after posedge, outputs sampled at negedge.
  task automatic cyc(input in_t v, output logic [8:0] got);
    logic [8:0] exp;
    drive(v);
    #4;
    exp = model_out(v);
    got = obs();
    chk("outputs", 32'(got), 32'(exp));
    chk("stall_cycles", stall_cycles_o, m_cnt);
    @(posedge clk);
    model_step(v, exp);
    #1;
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{rst:1'b0, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, rd:5'd0,
          memread:1'b0, br:1'b0, mdu:1'b0, done:1'b0, req:1'b0, rdy:1'b0};
    return v;
  endfunction

  vec_t       tbl[10];
  in_t        v;
  logic [8:0] got;
  int         starts;
  logic [31:0] cnt0;

  initial begin
    // Power-up reset: DUT state is unknown until the first reset edge.
    v = idle(); v.rst = 1'b1;
    drive(v);
    @(posedge clk); #1;
    cyc(v, got);
    chk("reset_outputs", 32'(got), 32'h0);
    chk("reset_counter", stall_cycles_o, 32'h0);

    // ---------------- single-cycle vector table (state RUN) ----------------
    for (int i = 0; i < 10; i++) tbl[i].v = idle();
    tbl[0].exp = 9'b0_0000_0000;
    tbl[1].v.memread = 1; tbl[1].v.rd = 5; tbl[1].v.rs2 = 5; tbl[1].v.u2 = 1;
    tbl[1].exp = 9'b0_1100_0100;
    tbl[2].v.memread = 1; tbl[2].v.rd = 0; tbl[2].v.rs2 = 0; tbl[2].v.u2 = 1;
    tbl[2].exp = 9'b0_0000_0000;
    tbl[3].v.memread = 1; tbl[3].v.rd = 7; tbl[3].v.rs1 = 7; tbl[3].v.u1 = 0;
    tbl[3].exp = 9'b0_0000_0000;
    tbl[4].v.memread = 1; tbl[4].v.rd = 31; tbl[4].v.rs1 = 31; tbl[4].v.u1 = 1;
    tbl[4].exp = 9'b0_1100_0100;
    tbl[5].v = tbl[1].v; tbl[5].v.br = 1;
    tbl[5].exp = 9'b0_0000_1100;
    tbl[6].v.req = 1; tbl[6].v.rdy = 0; tbl[6].v.br = 1;
    tbl[6].exp = 9'b0_1111_0001;
    tbl[7].v.req = 1; tbl[7].v.rdy = 0; tbl[7].v.mdu = 1;
    tbl[7].exp = 9'b0_1111_0001;
    tbl[8].v.req = 1; tbl[8].v.rdy = 1;
    tbl[8].exp = 9'b0_0000_0000;
    tbl[9].v.done = 1;
    tbl[9].exp = 9'b0_0000_0000;
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, got);
      chk($sformatf("table[%0d]", i), 32'(got), 32'(tbl[i].exp));
    end

    // ---------------- MDU: 4 busy cycles after the start cycle ----------------
    cnt0 = stall_cycles_o; starts = 0;
    v = idle(); v.mdu = 1;
    for (int c = 0; c < 5; c++) begin
      cyc(v, got);
      starts += int'(got[8]);
      chk("mdu_busy_outs", 32'(got[7:0]), 32'h0000_00E2);
    end
    v.done = 1;
    cyc(v, got);
    starts += int'(got[8]);
    chk("mdu_done_release", 32'(got), 32'h0);
    chk("mdu_start_count", starts, 1);
    chk("mdu_stall_cycles", stall_cycles_o - cnt0, 32'd5);
    cyc(idle(), got);
    chk("mdu_back_to_run", 32'(got), 32'h0);

    // ---------------- MDU done during memory stall ----------------
    starts = 0;
    v = idle(); v.mdu = 1;
    cyc(v, got); starts += int'(got[8]);
    cyc(v, got); starts += int'(got[8]);
    v.req = 1; v.rdy = 0; v.done = 1;
    cyc(v, got); starts += int'(got[8]);
    chk("pend_memstall1", 32'(got), 32'h0F1);
    v.done = 0;
    cyc(v, got); starts += int'(got[8]);
    chk("pend_memstall2", 32'(got), 32'h0F1);
    v.rdy = 1;
    cyc(v, got); starts += int'(got[8]);
    chk("pend_release", 32'(got), 32'h0);
    cyc(idle(), got); starts += int'(got[8]);
    chk("pend_single_start", starts, 1);

    // ---------------- memory stall with a taken branch ----------------
    v = idle(); v.br = 1; v.req = 1; v.rdy = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(v, got);
      chk("memstall_branch", 32'(got), 32'h0F1);
    end
    v.req = 0;
    cyc(v, got);
    chk("branch_after_memstall", 32'(got), 32'h00C);

    // ---------------- reset in the middle of MDU_WAIT ----------------
    v = idle(); v.mdu = 1;
    for (int c = 0; c < 3; c++) cyc(v, got);
    v.rst = 1;
    cyc(v, got);
    chk("reset_cycle_no_start", 32'(got[8]), 32'h0);
    cyc(idle(), got);
    chk("after_reset_outputs", 32'(got), 32'h0);
    chk("after_reset_counter", stall_cycles_o, 32'h0);

    // ---------------- random traffic against the model ----------------
    for (int c = 0; c < 600; c++) begin
      v.rst     = ($urandom_range(0, 99) < 2);
      v.rd      = 5'($urandom_range(0, 3));
      v.rs1     = 5'($urandom_range(0, 3));
      v.rs2     = 5'($urandom_range(0, 3));
      v.u1      = 1'($urandom);
      v.u2      = 1'($urandom);
      v.memread = ($urandom_range(0, 99) < 40);
      v.br      = ($urandom_range(0, 99) < 15);
      v.mdu     = ($urandom_range(0, 99) < 25);
      v.done    = ($urandom_range(0, 99) < 20);
      v.req     = ($urandom_range(0, 99) < 35);
      v.rdy     = 1'($urandom);
      cyc(v, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
